adder_sum_accumulator: RTL and testbench
========================================

Name: adder_sum_accumulator

Overview:
- Downstream consumer of the 4-bit adder's sum output.
- Accepts one sum per cycle over a valid/ready handshake and accumulates a fixed-size batch of COUNT sums into a wider register.
- Presents the batch total over a second valid/ready handshake.
- Used as the result-collection stage that the adder verification environment scores against.

Parameters:
SUM_W, 5, width of incoming sum (4-bit sum plus carry-out)
ACC_W, 12, width of accumulated total; must be >= SUM_W
COUNT, 8, sums per batch; legal range 1..255

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
clear_i  input  1  synchronous batch abort/clear, highest priority after reset
sum_i  input  SUM_W  unsigned sum from adder
sum_valid_i  input  1  sum_i valid
sum_ready_o  output  1  block can accept sum_i
acc_o  output  ACC_W  batch total, registered
acc_valid_o  output  1  acc_o holds a completed batch
acc_ready_i  input  1  consumer takes acc_o
sat_o  output  1  batch total saturated; qualified by acc_valid_o
cnt_o  output  8  sums accepted in current batch

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; acc_o=0, cnt_o=0, sat_o=0, acc_valid_o=0, sum_ready_o=0 while rst_n is low. After deassertion, sum_ready_o follows state (IDLE gives 1).
- Input transfer occurs on a rising edge with sum_valid_i=1 and sum_ready_o=1. Output transfer occurs with acc_valid_o=1 and acc_ready_i=1.
- sum_ready_o is combinational from state only: 1 in IDLE and ACCUM, 0 in HOLD. It never depends on sum_valid_i.
- IDLE, on input transfer:
  - acc <= zero-extended sum_i; cnt <= 1; sat <= 0.
  - Next state is ACCUM, or HOLD if COUNT==1.
- IDLE, no transfer: hold.
- ACCUM, on input transfer:
  - acc <= acc + sum_i, computed at ACC_W+1 bits.
  - If the result exceeds 2^ACC_W-1: acc <= 2^ACC_W-1 and sat <= 1 (sticky for the batch).
  - cnt <= cnt+1. If cnt+1==COUNT, next state is HOLD.
- HOLD:
  - acc_valid_o=1; acc_o, sat_o and cnt_o (==COUNT) stable until the output transfer.
  - On output transfer, next cycle: IDLE, acc_valid_o=0, acc_o=0, cnt_o=0, sat_o=0.
  - While acc_ready_i=0, hold indefinitely; no input accepted.
- Latency: acc_valid_o rises on the edge that accepts the COUNT-th sum, so it is visible the following cycle.
- Throughput: COUNT input cycles plus at least 1 HOLD cycle per batch. No overlap of input and output transfer.
- Once acc_valid_o is asserted, it is not deasserted until the output transfer, clear_i, or reset.
- clear_i=1 on an edge, in any state:
  - State IDLE; acc, cnt, sat and acc_valid_o go to 0.
  - Any simultaneous input or output transfer is discarded; the consumer must treat a cleared HOLD as dropped.
- Asynchronous reset mid-batch: partial sums are discarded immediately.
- Saturated value stays at max; later sums in the same batch do not wrap.
- sum_i bits are never truncated; zero-extension only.
- No X propagation: while sum_valid_i=0, sum_i is ignored.

Test Plan:
- Reset then feed sums 1,2,...,8 with valid held high and acc_ready_i=1 → sum_ready_o high for 8 cycles; acc_valid_o=1 for one cycle with acc_o=36, sat_o=0, cnt_o=8; block back in IDLE.
- Same batch with acc_ready_i=0 for 5 cycles after completion → sum_ready_o=0 and acc_o=36 stable for the 5 cycles; a pending sum_valid_i is not consumed until after the handshake.
- ACC_W=6, COUNT=8, eight sums of 31 → acc_o=63, sat_o=1. Next batch of eight 1s → acc_o=8, sat_o=0.
- Feed 3 sums (10,10,10), pulse clear_i, then a full batch of eight 2s → acc_o=16; the partial batch has no effect.
- Assert rst_n=0 asynchronously mid-batch after 4 sums → outputs are 0 before the next clock edge. After release, a new batch of eight 5s gives acc_o=40.
- COUNT=1: single sum 17 → HOLD immediately; acc_o=17 next cycle. Randomized valid gaps across 100 batches match the scoreboard sum.

Source files
------------

// File: rtl/adder_sum_accumulator.sv
// Collects a batch of COUNT adder sums into a wide total
// and hands the total to a consumer over valid/ready.
module adder_sum_accumulator #(
  parameter int SUM_W = 5,
  parameter int ACC_W = 12,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [SUM_W-1:0] sum_i,
  input  logic             sum_valid_i,
  output logic             sum_ready_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             sat_o,
  output logic [7:0]       cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(COUNT);
  localparam int         EXT_W    = ACC_W + 1 - SUM_W;

  state_t           state;
  state_t           state_n;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_n;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_n;
  logic             sat_q;
  logic             sat_n;

  logic             in_xfer;
  logic             out_xfer;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   sum_wide;
  logic [7:0]       cnt_inc;

  // handshake qualifiers; ready is forced low while in reset
  always_comb begin
    sum_ready_o = rst_n && (state != HOLD);
    acc_valid_o = (state == HOLD);
    in_xfer     = sum_valid_i && sum_ready_o;
    out_xfer    = acc_valid_o && acc_ready_i;
  end

  // one extra bit of headroom exposes overflow past ACC_W
  always_comb begin
    sum_ext  = {{EXT_W{1'b0}}, sum_i};
    sum_wide = {1'b0, acc_q} + sum_ext;
    cnt_inc  = cnt_q + 8'd1;
  end

  // next-state and datapath update
  always_comb begin
    state_n = state;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    sat_n   = sat_q;
    if (clear_i) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      sat_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_xfer) begin
            acc_n   = sum_ext[ACC_W-1:0];
            cnt_n   = 8'd1;
            sat_n   = 1'b0;
            state_n = (CNT_LAST == 8'd1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            if (sum_wide[ACC_W]) begin
              acc_n = '1;
              sat_n = 1'b1;
            end else begin
              acc_n = sum_wide[ACC_W-1:0];
            end
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            sat_n   = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          sat_n   = 1'b0;
        end
      endcase
    end
  end

  // state and batch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_n;
      acc_q <= acc_n;
      cnt_q <= cnt_n;
      sat_q <= sat_n;
    end
  end

  // registered outputs
  always_comb begin
    acc_o = acc_q;
    cnt_o = cnt_q;
    sat_o = sat_q;
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator:
// default, narrow-saturating and single-sum instances.
module tb_adder_sum_accumulator;

  logic clk;
  logic rst_n;

  logic        clr;
  logic [4:0]  sum;
  logic        vld;
  logic        srdy;
  logic [11:0] acc;
  logic        avld;
  logic        ardy;
  logic        sat;
  logic [7:0]  cnt;

  logic        s_clr;
  logic [4:0]  s_sum;
  logic        s_vld;
  logic        s_srdy;
  logic [5:0]  s_acc;
  logic        s_avld;
  logic        s_ardy;
  logic        s_sat;
  logic [7:0]  s_cnt;

  logic        o_clr;
  logic [4:0]  o_sum;
  logic        o_vld;
  logic        o_srdy;
  logic [11:0] o_acc;
  logic        o_avld;
  logic        o_ardy;
  logic        o_sat;
  logic [7:0]  o_cnt;

  int checks;
  int failures;

  adder_sum_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clr),
    .sum_i(sum), .sum_valid_i(vld), .sum_ready_o(srdy),
    .acc_o(acc), .acc_valid_o(avld), .acc_ready_i(ardy),
    .sat_o(sat), .cnt_o(cnt)
  );

  adder_sum_accumulator #(.ACC_W(6)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear_i(s_clr),
    .sum_i(s_sum), .sum_valid_i(s_vld), .sum_ready_o(s_srdy),
    .acc_o(s_acc), .acc_valid_o(s_avld), .acc_ready_i(s_ardy),
    .sat_o(s_sat), .cnt_o(s_cnt)
  );

  adder_sum_accumulator #(.COUNT(1)) u_one (
    .clk(clk), .rst_n(rst_n), .clear_i(o_clr),
    .sum_i(o_sum), .sum_valid_i(o_vld), .sum_ready_o(o_srdy),
    .acc_o(o_acc), .acc_valid_o(o_avld), .acc_ready_i(o_ardy),
    .sat_o(o_sat), .cnt_o(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [4:0] v);
    for (int i = 0; i < n; i++) begin
      sum = v;
      vld = 1'b1;
      tick();
    end
    vld = 1'b0;
    sum = 5'h1f;
  endtask

  int exp_sum;
  int k;
  int gap;
  int hold;
  logic [4:0] v;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clr = 0; sum = 0; vld = 0; ardy = 1;
    s_clr = 0; s_sum = 0; s_vld = 0; s_ardy = 1;
    o_clr = 0; o_sum = 0; o_vld = 0; o_ardy = 1;
    #1;
    chk("rst_acc", acc, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_avld", avld, 0);
    chk("rst_srdy", srdy, 0);
    chk("rst_sat", sat, 0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("idle_srdy", srdy, 1);
    tick();

    // batch 1..8, consumer always ready
    for (int i = 1; i <= 8; i++) begin
      sum = 5'(i);
      vld = 1'b1;
      chk("b1_srdy", srdy, 1);
      tick();
    end
    vld = 1'b0;
    chk("b1_avld", avld, 1);
    chk("b1_acc", acc, 36);
    chk("b1_sat", sat, 0);
    chk("b1_cnt", cnt, 8);
    chk("b1_srdy_hold", srdy, 0);
    tick();
    chk("b1_avld_off", avld, 0);
    chk("b1_acc_clr", acc, 0);
    chk("b1_cnt_clr", cnt, 0);
    chk("b1_idle", srdy, 1);

    // back-pressure for 5 cycles with a pending sum
    ardy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      sum = 5'(i);
      vld = 1'b1;
      tick();
    end
    sum = 5'd3;
    vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_srdy", srdy, 0);
      chk("bp_avld", avld, 1);
      chk("bp_acc", acc, 36);
      chk("bp_cnt", cnt, 8);
      tick();
    end
    ardy = 1'b1;
    tick();
    chk("bp_done_cnt", cnt, 0);
    chk("bp_done_acc", acc, 0);
    tick();
    vld = 1'b0;
    chk("bp_pending_acc", acc, 3);
    chk("bp_pending_cnt", cnt, 1);

    // clear discards partial batch and a simultaneous sum
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr0_cnt", cnt, 0);
    feed(3, 5'd10);
    chk("part_acc", acc, 30);
    sum = 5'd10;
    vld = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vld = 1'b0;
    chk("clr_acc", acc, 0);
    chk("clr_cnt", cnt, 0);
    chk("clr_srdy", srdy, 1);
    feed(8, 5'd2);
    chk("after_clr_acc", acc, 16);
    chk("after_clr_avld", avld, 1);
    tick();

    // saturation on the narrow instance
    for (int i = 0; i < 8; i++) begin
      s_sum = 5'd31;
      s_vld = 1'b1;
      tick();
    end
    s_vld = 1'b0;
    chk("sat_acc", s_acc, 63);
    chk("sat_flag", s_sat, 1);
    chk("sat_avld", s_avld, 1);
    tick();
    chk("sat_flag_clr", s_sat, 0);
    for (int i = 0; i < 8; i++) begin
      s_sum = 5'd1;
      s_vld = 1'b1;
      tick();
    end
    s_vld = 1'b0;
    chk("sat2_acc", s_acc, 8);
    chk("sat2_flag", s_sat, 0);
    tick();

    // asynchronous reset mid-batch
    feed(4, 5'd5);
    chk("ar_cnt_pre", cnt, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_acc", acc, 0);
    chk("ar_cnt", cnt, 0);
    chk("ar_srdy", srdy, 0);
    chk("ar_avld", avld, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("ar_srdy_rel", srdy, 1);
    feed(8, 5'd5);
    chk("ar_acc_new", acc, 40);
    chk("ar_cnt_new", cnt, 8);
    tick();

    // single-sum batches
    o_sum = 5'd17;
    o_vld = 1'b1;
    tick();
    o_vld = 1'b0;
    chk("one_avld", o_avld, 1);
    chk("one_acc", o_acc, 17);
    chk("one_cnt", o_cnt, 1);
    chk("one_srdy", o_srdy, 0);
    tick();
    chk("one_idle", o_avld, 0);
    o_sum = 5'd31;
    o_vld = 1'b1;
    tick();
    o_vld = 1'b0;
    chk("one_acc2", o_acc, 31);
    tick();

    // random gaps and back-pressure against a running sum
    for (int b = 0; b < 100; b++) begin
      exp_sum = 0;
      k = 0;
      gap = 0;
      while (k < 8) begin
        if ($urandom_range(0, 2) == 0 && gap < 3) begin
          vld = 1'b0;
          sum = 5'($urandom_range(0, 31));
          gap++;
        end else begin
          v = 5'($urandom_range(0, 31));
          sum = v;
          vld = 1'b1;
          exp_sum += int'(v);
          k++;
          gap = 0;
        end
        tick();
      end
      vld = 1'b0;
      ardy = 1'b0;
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) tick();
      chk("rnd_avld", avld, 1);
      chk("rnd_acc", acc, exp_sum);
      ardy = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
